// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode types: the queued instruction entry and the default issue width.
package inst_fetch_queue_pkg;

  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_LANES  = 2;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] address;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/lane_compactor.sv
// Maps a sparse lane-valid mask to dense slot offsets (exclusive prefix popcount) and a total.
module lane_compactor
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned LANES = FETCH_LANES
) (
  input  logic [LANES-1:0]                          write_en,
  output logic [LANES-1:0][$clog2(LANES+1)-1:0]     offset_c,
  output logic [$clog2(LANES+1)-1:0]                pushes_c
);

  localparam int unsigned OFF_W = $clog2(LANES + 1);

  logic [OFF_W-1:0] run;

  always_comb begin
    run      = '0;
    offset_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      offset_c[l] = run;
      run         = run + OFF_W'(write_en[l]);
    end
    pushes_c = run;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-lane fetch->decode instruction queue with first-word fall-through and
// branch flush that can retain the delay-slot entry.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LANES  = FETCH_LANES,
  parameter int unsigned DATA_W = FETCH_DATA_W,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              flush_keep,
  input  logic [LANES-1:0]                  write_en,
  input  logic [LANES-1:0][DATA_W-1:0]      write_data,
  input  logic [LANES-1:0][ADDR_W-1:0]      write_address,
  input  logic [$clog2(LANES+1)-1:0]        read_count,
  output logic [LANES-1:0][DATA_W-1:0]      data_out,
  output logic [LANES-1:0][ADDR_W-1:0]      address_out,
  output logic [LANES-1:0]                  valid_out,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty,
  output logic                              almost_empty,
  output logic                              full,
  output logic                              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned RC_W  = $clog2(LANES + 1);

  fetch_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [LANES-1:0][RC_W-1:0] lane_off;
  logic [RC_W-1:0]            lane_pushes;

  logic [CNT_W-1:0] rc_ext, pops, surv;
  logic [PTR_W-1:0] rd_after;
  logic             full_now, push_ok;

  logic [LANES-1:0]       lane_we;
  logic [PTR_W-1:0]       lane_idx   [LANES];
  fetch_entry_t           lane_entry [LANES];

  lane_compactor #(.LANES(LANES)) u_compactor (
    .write_en (write_en),
    .offset_c (lane_off),
    .pushes_c (lane_pushes)
  );

  // Full is judged on the current occupancy; a same-cycle pop never frees room.
  assign full_now = (CNT_W'(DEPTH) - count_q) < CNT_W'(LANES);
  assign push_ok  = !full_now && !flush;

  always_comb begin
    rc_ext   = CNT_W'(read_count);
    pops     = (rc_ext < count_q) ? rc_ext : count_q;
    surv     = count_q - pops;
    rd_after = rd_ptr_q + PTR_W'(pops);
    rd_ptr_d   = rd_after;
    wr_ptr_d   = wr_ptr_q;
    count_d    = surv;
    overflow_d = overflow_q;
    if (flush) begin
      overflow_d = 1'b0;
      if (flush_keep && (surv != '0)) begin
        count_d  = CNT_W'(1);
        wr_ptr_d = rd_after + PTR_W'(1);
      end else begin
        count_d  = '0;
        wr_ptr_d = rd_after;
      end
    end else if (push_ok) begin
      count_d  = surv + CNT_W'(lane_pushes);
      wr_ptr_d = wr_ptr_q + PTR_W'(lane_pushes);
    end else if (write_en != '0) begin
      overflow_d = 1'b1;
    end
  end

  // Per-lane array write ports; slot indices wrap naturally through PTR_W arithmetic.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_we[l]            = write_en[l] && push_ok;
      lane_idx[l]           = wr_ptr_q + PTR_W'(lane_off[l]);
      lane_entry[l].address = FETCH_ADDR_W'(write_address[l]);
      lane_entry[l].data    = FETCH_DATA_W'(write_data[l]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane_we[l]) mem_q[lane_idx[l]] <= lane_entry[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Fall-through read view of the oldest LANES entries.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      data_out[i]    = DATA_W'(mem_q[rd_ptr_q + PTR_W'(i)].data);
      address_out[i] = ADDR_W'(mem_q[rd_ptr_q + PTR_W'(i)].address);
      valid_out[i]   = count_q > CNT_W'(i);
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign almost_empty = count_q < CNT_W'(LANES);
  assign full         = full_now;
  assign overflow     = overflow_q;

endmodule
